// File: rtl/seg7_scan_ctrl.sv
// Scan controller for a shared hex-to-7-segment decoder: steps one-hot digit enables over a
// double-buffered nibble frame, with an all-off guard interval after every digit.
module seg7_scan_ctrl #(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned CNT_WIDTH    = 16,
   parameter int unsigned GUARD_CYCLES = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [CNT_WIDTH-1:0]      show_cycles,
   input  logic                      load_valid,
   output logic                      load_ready,
   input  logic [4*NUM_DIGITS-1:0]   load_data,
   input  logic [NUM_DIGITS-1:0]     load_blank,
   output logic [3:0]                nibble_out,
   output logic [NUM_DIGITS-1:0]     digit_sel,
   output logic                      frame_done
);

   localparam int unsigned IdxW = $clog2(NUM_DIGITS);
   localparam int unsigned DataW = 4 * NUM_DIGITS;
   localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_DIGITS - 1);
   localparam logic [CNT_WIDTH-1:0] GuardLast =
      (GUARD_CYCLES > 0) ? CNT_WIDTH'(GUARD_CYCLES - 1) : '0;

   typedef enum logic [1:0] {StIdle, StShow, StGuard} state_e;

   state_e                state_q, state_d;
   logic [IdxW-1:0]       idx_q, idx_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0]  last_q, last_d;
   logic [DataW-1:0]      active_data_q, active_data_d;
   logic [NUM_DIGITS-1:0] active_blank_q, active_blank_d;
   logic [DataW-1:0]      shadow_data_q, shadow_data_d;
   logic [NUM_DIGITS-1:0] shadow_blank_q, shadow_blank_d;
   logic                  pending_q, pending_d;
   logic                  arm_q, arm_d;
   logic [3:0]            nibble_q, nibble_d;
   logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;
   logic                  frame_done_q, frame_done_d;

   logic accept;
   logic xfer;
   logic advance;
   logic enter_show;
   logic go_idle;

   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      cnt_d          = cnt_q;
      last_d         = last_q;
      active_data_d  = active_data_q;
      active_blank_d = active_blank_q;
      shadow_data_d  = shadow_data_q;
      shadow_blank_d = shadow_blank_q;
      pending_d      = pending_q;
      nibble_d       = nibble_q;
      digit_sel_d    = '0;
      frame_done_d   = 1'b0;
      xfer           = 1'b0;
      advance        = 1'b0;
      enter_show     = 1'b0;
      go_idle        = 1'b0;

      accept = load_valid & ~pending_q;
      if (accept) begin
         shadow_data_d  = load_data;
         shadow_blank_d = load_blank;
         pending_d      = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            // Idle transfer waits one extra cycle after pending is seen (arm_q).
            xfer = pending_q & arm_q;
            if (enable) begin
               idx_d      = '0;
               enter_show = 1'b1;
            end
         end
         StShow: begin
            if (!enable) begin
               go_idle = 1'b1;
            end else if (cnt_q == last_q) begin
               if (GUARD_CYCLES > 0) begin
                  state_d = StGuard;
                  cnt_d   = '0;
               end else begin
                  advance = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end
         StGuard: begin
            if (!enable) begin
               go_idle = 1'b1;
            end else if (cnt_q == GuardLast) begin
               advance = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end
         default: go_idle = 1'b1;
      endcase

      if (advance) begin
         enter_show = 1'b1;
         if (idx_q == IdxLast) begin
            idx_d        = '0;
            frame_done_d = 1'b1;
            xfer         = pending_q;
         end else begin
            idx_d = idx_q + IdxW'(1);
         end
      end

      if (enter_show) begin
         state_d = StShow;
         cnt_d   = '0;
         last_d  = (show_cycles == '0) ? '0 : show_cycles - CNT_WIDTH'(1);
      end

      if (go_idle) begin
         state_d = StIdle;
         idx_d   = '0;
         cnt_d   = '0;
      end

      if (xfer) begin
         active_data_d  = shadow_data_q;
         active_blank_d = shadow_blank_q;
         pending_d      = 1'b0;
      end

      arm_d = pending_q & pending_d;

      // Outputs are computed from next state so they line up with the registered state.
      if (state_d == StShow) begin
         digit_sel_d = (NUM_DIGITS'(1) << idx_d) & ~active_blank_d;
         nibble_d    = active_data_d[{idx_d, 2'b00} +: 4];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= StIdle;
         idx_q          <= '0;
         cnt_q          <= '0;
         last_q         <= '0;
         active_data_q  <= '0;
         active_blank_q <= '0;
         shadow_data_q  <= '0;
         shadow_blank_q <= '0;
         pending_q      <= 1'b0;
         arm_q          <= 1'b0;
         nibble_q       <= '0;
         digit_sel_q    <= '0;
         frame_done_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         cnt_q          <= cnt_d;
         last_q         <= last_d;
         active_data_q  <= active_data_d;
         active_blank_q <= active_blank_d;
         shadow_data_q  <= shadow_data_d;
         shadow_blank_q <= shadow_blank_d;
         pending_q      <= pending_d;
         arm_q          <= arm_d;
         nibble_q       <= nibble_d;
         digit_sel_q    <= digit_sel_d;
         frame_done_q   <= frame_done_d;
      end
   end

   assign load_ready = ~pending_q;
   assign nibble_out = nibble_q;
   assign digit_sel  = digit_sel_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: a guarded 4-digit instance driven from a cycle table,
// plus a guard-less instance and hand-written enable/reset corner sequences.
module tb_seg7_scan_ctrl;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        en0, lv0, rdy0, fd0;
   logic [15:0] sc0, ld0;
   logic [3:0]  lb0, nib0, sel0;
   logic        en1, lv1, rdy1, fd1;
   logic [15:0] sc1, ld1;
   logic [3:0]  lb1, nib1, sel1;

   seg7_scan_ctrl #(.NUM_DIGITS(4), .CNT_WIDTH(16), .GUARD_CYCLES(2)) u_dut0 (
      .clk(clk), .reset(reset), .enable(en0), .show_cycles(sc0), .load_valid(lv0),
      .load_ready(rdy0), .load_data(ld0), .load_blank(lb0), .nibble_out(nib0),
      .digit_sel(sel0), .frame_done(fd0)
   );

   seg7_scan_ctrl #(.NUM_DIGITS(4), .CNT_WIDTH(16), .GUARD_CYCLES(0)) u_dut1 (
      .clk(clk), .reset(reset), .enable(en1), .show_cycles(sc1), .load_valid(lv1),
      .load_ready(rdy1), .load_data(ld1), .load_blank(lb1), .nibble_out(nib1),
      .digit_sel(sel1), .frame_done(fd1)
   );

   typedef struct {
      logic        en;
      logic        lv;
      logic [15:0] ld;
      logic [3:0]  lb;
      logic [3:0]  sel;
      logic [3:0]  nib;
      logic        fd;
      logic        rdy;
   } vec_t;

   vec_t tbl[81];
   int checks = 0;
   int failures = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      logic [15:0] data;
      logic [3:0]  blank;
      logic [3:0]  one;
      int f, ph, d, p;

      // Expected per-cycle picture of the guarded instance: 4 digits x (3 show + 2 guard).
      for (int k = 0; k <= 80; k++) begin
         f  = k / 20;
         p  = k % 20;
         d  = p / 5;
         ph = p % 5;
         data  = (f < 2) ? 16'h4321 : (f == 2) ? 16'hABCD : 16'h8765;
         blank = (f >= 3) ? 4'b0101 : 4'b0000;
         one   = 4'b0001 << d;
         tbl[k].en  = 1'b1;
         tbl[k].nib = data[d*4 +: 4];
         tbl[k].sel = (ph < 3 && !blank[d]) ? one : 4'b0000;
         tbl[k].fd  = (p == 0 && k > 0);
         tbl[k].rdy = !((k >= 23 && k <= 39) || (k >= 45 && k <= 59));
         tbl[k].lv  = 1'b0;
         tbl[k].ld  = 16'h0000;
         tbl[k].lb  = 4'b0000;
         if (k == 23) begin
            tbl[k].lv = 1'b1;
            tbl[k].ld = 16'hABCD;
         end else if (k >= 24 && k <= 38) begin
            tbl[k].lv = 1'b1;
            tbl[k].ld = 16'h9999;
            tbl[k].lb = 4'b1111;
         end else if (k == 45) begin
            tbl[k].lv = 1'b1;
            tbl[k].ld = 16'h8765;
            tbl[k].lb = 4'b0101;
         end
      end

      reset = 1'b1;
      en0 = 0; lv0 = 0; sc0 = 16'd3; ld0 = '0; lb0 = '0;
      en1 = 0; lv1 = 0; sc1 = 16'd0; ld1 = '0; lb1 = '0;
      tick();
      tick();
      reset = 1'b0;
      chk("reset_sel", sel0, 4'b0000);
      chk("reset_nib", nib0, 4'h0);
      chk("reset_fd", fd0, 1'b0);
      chk("reset_rdy", rdy0, 1'b1);

      // Idle load: ready low for exactly two cycles, no digit lit.
      lv0 = 1'b1; ld0 = 16'h4321; lb0 = 4'b0000;
      tick();
      lv0 = 1'b0;
      chk("idle_load_rdy_c1", rdy0, 1'b0);
      chk("idle_load_sel_c1", sel0, 4'b0000);
      tick();
      chk("idle_load_rdy_c2", rdy0, 1'b0);
      chk("idle_load_sel_c2", sel0, 4'b0000);
      tick();
      chk("idle_load_rdy_c3", rdy0, 1'b1);
      chk("idle_load_sel_c3", sel0, 4'b0000);

      for (int k = 0; k <= 80; k++) begin
         en0 = tbl[k].en;
         lv0 = tbl[k].lv;
         ld0 = tbl[k].ld;
         lb0 = tbl[k].lb;
         tick();
         chk($sformatf("row%0d_sel", k), sel0, tbl[k].sel);
         chk($sformatf("row%0d_nib", k), nib0, tbl[k].nib);
         chk($sformatf("row%0d_fd", k), fd0, tbl[k].fd);
         chk($sformatf("row%0d_rdy", k), rdy0, tbl[k].rdy);
      end
      lv0 = 1'b0;

      // Enable drop mid-SHOW of digit 1, then restart from digit 0.
      repeat (5) tick();
      chk("pre_drop_sel", sel0, 4'b0010);
      chk("pre_drop_nib", nib0, 4'h6);
      en0 = 1'b0;
      tick();
      chk("drop_sel", sel0, 4'b0000);
      chk("drop_fd", fd0, 1'b0);
      tick();
      chk("drop_sel_2", sel0, 4'b0000);
      en0 = 1'b1;
      tick();
      chk("restart_nib", nib0, 4'h5);
      chk("restart_sel", sel0, 4'b0000);
      chk("restart_fd", fd0, 1'b0);
      repeat (5) tick();
      chk("restart_d1_sel", sel0, 4'b0010);
      chk("restart_d1_nib", nib0, 4'h6);

      // Reset in GUARD with a frame pending.
      lv0 = 1'b1; ld0 = 16'hFFFF; lb0 = 4'b0000;
      tick();
      lv0 = 1'b0;
      chk("pend_rdy", rdy0, 1'b0);
      tick();
      tick();
      chk("guard_sel", sel0, 4'b0000);
      chk("guard_nib_hold", nib0, 4'h6);
      reset = 1'b1;
      tick();
      chk("midrst_sel", sel0, 4'b0000);
      chk("midrst_nib", nib0, 4'h0);
      chk("midrst_fd", fd0, 1'b0);
      chk("midrst_rdy", rdy0, 1'b1);
      reset = 1'b0;
      en0 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("postrst_rdy%0d", i), rdy0, 1'b1);
      end
      en0 = 1'b1;
      tick();
      chk("postrst_sel", sel0, 4'b0001);
      chk("postrst_nib", nib0, 4'h0);
      en0 = 1'b0;

      // Guard-less instance with show_cycles = 0: one digit per cycle.
      lv1 = 1'b1; ld1 = 16'h4321; lb1 = 4'b0000;
      tick();
      lv1 = 1'b0;
      tick();
      tick();
      chk("g0_rdy", rdy1, 1'b1);
      en1 = 1'b1; sc1 = 16'd0;
      for (int k = 0; k < 12; k++) begin
         tick();
         one = 4'b0001 << (k % 4);
         chk($sformatf("g0_row%0d_sel", k), sel1, one);
         chk($sformatf("g0_row%0d_nib", k), nib1, 4'((k % 4) + 1));
         chk($sformatf("g0_row%0d_fd", k), fd1, (k % 4 == 0 && k > 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
